// File: rtl/marker_pkg.sv
// Shared word constants, K-flag encodings and marker-type enum for the marker sequencer.
package marker_pkg;

    localparam logic [15:0] Comma             = 16'hBC3C;
    localparam logic [15:0] EventStartK       = 16'h1C11;
    localparam logic [15:0] EventStartKn      = 16'h1CEE;
    localparam logic [15:0] Clock40MHzMarkerK  = 16'h1C10;
    localparam logic [15:0] Clock40MHzMarkerKn = 16'h1CEF;
    localparam logic [15:0] DelayMeasureK     = 16'h1C12;
    localparam logic [15:0] DelayMeasureKn    = 16'h1CED;
    localparam logic [15:0] DiagnosticK       = 16'h1C13;
    localparam logic [15:0] DCSTimeoutK       = 16'h1C14;
    localparam logic [15:0] RetransK          = 16'h1C15;
    localparam logic [15:0] RetransKn         = 16'h1CEA;
    localparam logic [15:0] DCSRequestK       = 16'h1C00;
    localparam logic [15:0] UnusedK           = 16'h1C20;
    localparam logic [15:0] IllegalK          = 16'h1234;

    localparam logic [1:0] KChar = 2'b11;
    localparam logic [1:0] KCmd  = 2'b10;
    localparam logic [1:0] KWord = 2'b00;

    // Types 8..15 are deliberately malformed markers for negative testing.
    typedef enum logic [3:0] {
        MkEventStart, MkClock40, MkDelayMeasure, MkRetrans,
        MkDiagnostic, MkDcsTimeout, MkDcsRequest, MkUnused,
        MkBadEventHalf, MkBadClockHalf, MkBadDelay, MkBadRetrans,
        MkBadEventPair, MkBadClockPair, MkBadRetransShort, MkIllegal
    } marker_type_e;

    function automatic logic [1:0] word_len(marker_type_e t);
        logic [1:0] len;
        case (t)
            MkRetrans, MkBadRetrans: len = 2'd3;
            MkEventStart, MkClock40, MkBadDelay,
            MkBadEventPair, MkBadClockPair, MkBadRetransShort: len = 2'd2;
            default: len = 2'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/marker_cmd_fifo.sv
// Synchronous command FIFO with an extra wrap bit on each pointer to tell full from empty.
module marker_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             RX_CLK,
    input  logic             RX_RESETN,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full, do_push, do_pop;

    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign push_ready = ~full;
    assign do_push    = push_valid & ~full;
    assign do_pop     = pop & ~empty;
    assign pop_data   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge RX_CLK) begin
        if (!RX_RESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
                wr_ptr_q                <= wr_ptr_q + PtrOne;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

endmodule

// File: rtl/marker_sequencer.sv
// Queued marker generator: pops commands and plays each back as preamble commas plus marker
// words, repeated with an auto-incrementing sequence number.
module marker_sequencer
    import marker_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RPT_W      = 4,
    parameter int unsigned PRE_W      = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             RX_CLK,
    input  logic             RX_RESETN,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_type,
    input  logic [3:0]       cmd_seq,
    input  logic [RPT_W-1:0] cmd_repeat,
    input  logic [PRE_W-1:0] cmd_preamble,
    input  logic             enable,
    output logic             busy,
    output logic [CNT_W-1:0] markers_sent,
    output logic [15:0]      DATA_TO_TX,
    output logic [1:0]       KCHAR_TO_TX
);

    localparam int unsigned EntryW = 8 + RPT_W + PRE_W;
    localparam logic [RPT_W-1:0] RptOne = 1;
    localparam logic [PRE_W-1:0] PreOne = 1;
    localparam logic [CNT_W-1:0] CntOne = 1;

    typedef enum logic [1:0] {StIdle, StPre, StMk} state_e;

    state_e             state_q;
    marker_type_e       type_q;
    logic [3:0]         seq_q;
    logic [RPT_W-1:0]   rpt_q;
    logic [PRE_W-1:0]   pre_q, pre_cnt_q;
    logic [1:0]         idx_q;
    logic [15:0]        data_q;
    logic [1:0]         k_q;
    logic [CNT_W-1:0]   sent_q;

    logic               fifo_empty, pop;
    logic [EntryW-1:0]  head;
    marker_type_e       head_type;
    logic [3:0]         head_seq;
    logic [RPT_W-1:0]   head_rpt;
    logic [PRE_W-1:0]   head_pre;

    marker_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EntryW)
    ) u_fifo (
        .RX_CLK     (RX_CLK),
        .RX_RESETN  (RX_RESETN),
        .push_valid (cmd_valid),
        .push_ready (cmd_ready),
        .push_data  ({cmd_type, cmd_seq, cmd_repeat, cmd_preamble}),
        .pop        (pop),
        .pop_data   (head),
        .empty      (fifo_empty)
    );

    assign pop       = (state_q == StIdle) & enable & ~fifo_empty;
    assign head_pre  = head[PRE_W-1:0];
    assign head_rpt  = head[PRE_W +: RPT_W];
    assign head_seq  = head[PRE_W+RPT_W +: 4];
    assign head_type = marker_type_e'(head[PRE_W+RPT_W+4 +: 4]);

    function automatic logic [17:0] word_at(marker_type_e t, logic [1:0] idx, logic [3:0] s);
        logic [17:0] w;
        w = {IllegalK, KCmd};
        case (t)
            MkEventStart:      w = (idx == 2'd0) ? {EventStartK, KCmd} : {EventStartKn, KCmd};
            MkClock40:         w = (idx == 2'd0) ? {Clock40MHzMarkerK, KCmd}
                                                 : {Clock40MHzMarkerKn, KCmd};
            MkDelayMeasure:    w = {DelayMeasureK, KCmd};
            MkRetrans:         w = (idx == 2'd0) ? {RetransK, KCmd} :
                                   (idx == 2'd1) ? {RetransKn, KCmd} : {s, s, s, s, KWord};
            MkDiagnostic:      w = {DiagnosticK, KCmd};
            MkDcsTimeout:      w = {DCSTimeoutK, KCmd};
            MkDcsRequest:      w = {DCSRequestK, KCmd};
            MkUnused:          w = {UnusedK, KCmd};
            MkBadEventHalf:    w = {EventStartK, KCmd};
            MkBadClockHalf:    w = {Clock40MHzMarkerKn, KCmd};
            MkBadDelay:        w = (idx == 2'd0) ? {DelayMeasureK, KCmd} : {DelayMeasureKn, KCmd};
            MkBadRetrans:      w = (idx == 2'd0) ? {RetransK, KCmd} :
                                   (idx == 2'd1) ? {RetransKn, KCmd} : {s, 4'h0, s, s, KWord};
            MkBadEventPair:    w = (idx == 2'd0) ? {EventStartK, KCmd}
                                                 : {Clock40MHzMarkerKn, KCmd};
            MkBadClockPair:    w = {Clock40MHzMarkerK, KCmd};
            MkBadRetransShort: w = (idx == 2'd0) ? {RetransK, KCmd} : {RetransKn, KCmd};
            MkIllegal:         w = {IllegalK, KCmd};
        endcase
        return w;
    endfunction

    // Outputs are loaded with the word to be shown in the state being entered.
    always_ff @(posedge RX_CLK) begin
        if (!RX_RESETN) begin
            state_q   <= StIdle;
            type_q    <= MkEventStart;
            seq_q     <= '0;
            rpt_q     <= '0;
            pre_q     <= '0;
            pre_cnt_q <= '0;
            idx_q     <= '0;
            data_q    <= Comma;
            k_q       <= KChar;
            sent_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        type_q <= head_type;
                        seq_q  <= head_seq;
                        rpt_q  <= (head_rpt == '0) ? RptOne : head_rpt;
                        pre_q  <= head_pre;
                        idx_q  <= '0;
                        if (head_pre != '0) begin
                            state_q    <= StPre;
                            pre_cnt_q  <= head_pre;
                            {data_q, k_q} <= {Comma, KChar};
                        end else begin
                            state_q    <= StMk;
                            {data_q, k_q} <= word_at(head_type, 2'd0, head_seq);
                        end
                    end else begin
                        {data_q, k_q} <= {Comma, KChar};
                    end
                end
                StPre: begin
                    if (pre_cnt_q == PreOne) begin
                        state_q       <= StMk;
                        idx_q         <= '0;
                        {data_q, k_q} <= word_at(type_q, 2'd0, seq_q);
                    end else begin
                        pre_cnt_q     <= pre_cnt_q - PreOne;
                        {data_q, k_q} <= {Comma, KChar};
                    end
                end
                StMk: begin
                    if (idx_q == word_len(type_q) - 2'd1) begin
                        if (sent_q != '1) begin
                            sent_q <= sent_q + CntOne;
                        end
                        seq_q <= seq_q + 4'd1;
                        rpt_q <= rpt_q - RptOne;
                        idx_q <= '0;
                        if (rpt_q > RptOne) begin
                            if (pre_q != '0) begin
                                state_q       <= StPre;
                                pre_cnt_q     <= pre_q;
                                {data_q, k_q} <= {Comma, KChar};
                            end else begin
                                state_q       <= StMk;
                                {data_q, k_q} <= word_at(type_q, 2'd0, seq_q + 4'd1);
                            end
                        end else begin
                            state_q       <= StIdle;
                            {data_q, k_q} <= {Comma, KChar};
                        end
                    end else begin
                        idx_q         <= idx_q + 2'd1;
                        {data_q, k_q} <= word_at(type_q, idx_q + 2'd1, seq_q);
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    {data_q, k_q} <= {Comma, KChar};
                end
            endcase
        end
    end

    assign busy         = (state_q != StIdle) | ~fifo_empty;
    assign markers_sent = sent_q;
    assign DATA_TO_TX   = data_q;
    assign KCHAR_TO_TX  = k_q;

endmodule

// File: tb/tb_marker_sequencer.sv
// Scoreboard bench for marker_sequencer: pushes commands, queues the expected marker words with
// the comma gap that must precede each, and a negedge monitor checks the output stream.
module tb_marker_sequencer;

    localparam int FD = 4;
    localparam int RW = 4;
    localparam int PW = 8;
    localparam int CW = 16;

    logic          RX_CLK = 1'b0;
    logic          RX_RESETN = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [3:0]    cmd_type = '0;
    logic [3:0]    cmd_seq = '0;
    logic [RW-1:0] cmd_repeat = '0;
    logic [PW-1:0] cmd_preamble = '0;
    logic          enable = 1'b0;
    logic          cmd_ready, busy;
    logic [CW-1:0] markers_sent;
    logic [15:0]   DATA_TO_TX;
    logic [1:0]    KCHAR_TO_TX;

    marker_sequencer #(
        .FIFO_DEPTH (FD),
        .RPT_W      (RW),
        .PRE_W      (PW),
        .CNT_W      (CW)
    ) dut (
        .RX_CLK       (RX_CLK),
        .RX_RESETN    (RX_RESETN),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type     (cmd_type),
        .cmd_seq      (cmd_seq),
        .cmd_repeat   (cmd_repeat),
        .cmd_preamble (cmd_preamble),
        .enable       (enable),
        .busy         (busy),
        .markers_sent (markers_sent),
        .DATA_TO_TX   (DATA_TO_TX),
        .KCHAR_TO_TX  (KCHAR_TO_TX)
    );

    always #5 RX_CLK = ~RX_CLK;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  k;
        int          gap;   // commas required before this word; -1 = don't care
    } exp_t;

    exp_t expq[$];
    exp_t mon_item;
    int   tests = 0;
    int   fails = 0;
    int   gap_cnt = 0;
    int   sent_model = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic put(input logic [15:0] d, input logic [1:0] k, input int gap);
        exp_t e;
        e.d = d;
        e.k = k;
        e.gap = gap;
        expq.push_back(e);
    endtask

    // Word lists per marker type, straight from the type table.
    task automatic add_marker(input int t, input logic [3:0] s, input int gap);
        case (t)
            0:  begin put(16'h1C11, 2'b10, gap); put(16'h1CEE, 2'b10, 0); end
            1:  begin put(16'h1C10, 2'b10, gap); put(16'h1CEF, 2'b10, 0); end
            2:  put(16'h1C12, 2'b10, gap);
            3:  begin put(16'h1C15, 2'b10, gap); put(16'h1CEA, 2'b10, 0);
                      put({s, s, s, s}, 2'b00, 0); end
            4:  put(16'h1C13, 2'b10, gap);
            5:  put(16'h1C14, 2'b10, gap);
            6:  put(16'h1C00, 2'b10, gap);
            7:  put(16'h1C20, 2'b10, gap);
            8:  put(16'h1C11, 2'b10, gap);
            9:  put(16'h1CEF, 2'b10, gap);
            10: begin put(16'h1C12, 2'b10, gap); put(16'h1CED, 2'b10, 0); end
            11: begin put(16'h1C15, 2'b10, gap); put(16'h1CEA, 2'b10, 0);
                      put({s, 4'h0, s, s}, 2'b00, 0); end
            12: begin put(16'h1C11, 2'b10, gap); put(16'h1CEF, 2'b10, 0); end
            13: begin put(16'h1C10, 2'b10, gap); put(16'h1C10, 2'b10, 0); end
            14: begin put(16'h1C15, 2'b10, gap); put(16'h1CEA, 2'b10, 0); end
            default: put(16'h1234, 2'b10, gap);
        endcase
    endtask

    task automatic model_cmd(input int t, input int s, input int r, input int p, input bit known);
        int n;
        n = (r == 0) ? 1 : r;
        for (int e = 0; e < n; e++) begin
            logic [3:0] sq;
            sq = 4'((s + e) % 16);
            add_marker(t, sq, (e == 0) ? (known ? 1 + p : -1) : p);
        end
        sent_model += n;
    endtask

    // known: the command will start right after an idle comma, so its lead gap is 1+preamble.
    task automatic push(input int t, input int s, input int r, input int p, input bit known,
                        output bit acc);
        @(negedge RX_CLK);
        cmd_valid    = 1'b1;
        cmd_type     = 4'(t);
        cmd_seq      = 4'(s);
        cmd_repeat   = RW'(r);
        cmd_preamble = PW'(p);
        acc          = cmd_ready;
        @(posedge RX_CLK);
        #1;
        cmd_valid = 1'b0;
        if (acc) begin
            gap_cnt = 0;
            model_cmd(t, s, r, p, known);
        end
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while ((busy || expq.size() != 0) && c < 2000) begin
            @(negedge RX_CLK);
            c++;
        end
        @(negedge RX_CLK);
        #1;
        check({name, "_timeout"}, 32'(c < 2000), 32'd1);
        check({name, "_queue_empty"}, expq.size(), 32'd0);
        check({name, "_markers_sent"}, 32'(markers_sent), sent_model);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    always @(negedge RX_CLK) begin
        if (mon_en) begin
            if (KCHAR_TO_TX == 2'b11) begin
                check("comma_data", 32'(DATA_TO_TX), 32'h0000BC3C);
                gap_cnt++;
            end else begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %h/%b expected comma", DATA_TO_TX,
                             KCHAR_TO_TX);
                end else begin
                    mon_item = expq.pop_front();
                    check("word_data", 32'(DATA_TO_TX), 32'(mon_item.d));
                    check("word_k", 32'(KCHAR_TO_TX), 32'(mon_item.k));
                    if (mon_item.gap >= 0) check("comma_gap", gap_cnt, mon_item.gap);
                end
                gap_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n, found;

        repeat (2) @(posedge RX_CLK);
        @(negedge RX_CLK);
        check("rst_data", 32'(DATA_TO_TX), 32'h0000BC3C);
        check("rst_k", 32'(KCHAR_TO_TX), 32'd3);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sent", 32'(markers_sent), 32'd0);
        @(posedge RX_CLK);
        #1;
        RX_RESETN = 1'b1;
        mon_en = 1'b1;
        repeat (8) begin
            @(negedge RX_CLK);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_ready", 32'(cmd_ready), 32'd1);
        end

        // Type 0 with six preamble commas.
        enable = 1'b1;
        push(0, 0, 1, 6, 1'b1, acc);
        check("t0_accept", 32'(acc), 32'd1);
        drain("t0_pre6");

        // Retransmit, seq wraps E -> F -> 0.
        push(3, 14, 3, 0, 1'b1, acc);
        drain("t3_rpt3");

        // Fill beyond depth while disabled.
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(i + 4, i, 1, 0, i != 0, acc);
            check("fill_accept", 32'(acc), 32'(i < FD));
            if (i == FD - 1) begin
                @(negedge RX_CLK);
                check("fill_ready_low", 32'(cmd_ready), 32'd0);
            end
        end
        @(negedge RX_CLK);
        enable = 1'b1;
        drain("fill_drain");

        // Bad retransmit then illegal word, one idle comma between.
        enable = 1'b0;
        push(11, 5, 1, 0, 1'b0, acc);
        push(15, 0, 1, 0, 1'b1, acc);
        @(negedge RX_CLK);
        enable = 1'b1;
        drain("t11_t15");

        // Randomized batches.
        for (int b = 0; b < 20; b++) begin
            enable = 1'b0;
            n = int'($urandom_range(1, FD));
            for (int i = 0; i < n; i++) begin
                push(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), i != 0, acc);
            end
            @(negedge RX_CLK);
            enable = 1'b1;
            drain("rand_batch");
        end

        // Reset in the middle of the second word of type 13.
        push(13, 0, 2, 0, 1'b1, acc);
        found = 0;
        for (int c = 0; c < 50 && found < 2; c++) begin
            @(negedge RX_CLK);
            if (KCHAR_TO_TX == 2'b10) found++;
        end
        check("mid_reset_reached", found, 32'd2);
        RX_RESETN = 1'b0;
        mon_en = 1'b0;
        @(negedge RX_CLK);
        check("mid_reset_data", 32'(DATA_TO_TX), 32'h0000BC3C);
        check("mid_reset_k", 32'(KCHAR_TO_TX), 32'd3);
        check("mid_reset_sent", 32'(markers_sent), 32'd0);
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_ready", 32'(cmd_ready), 32'd1);
        @(posedge RX_CLK);
        #1;
        RX_RESETN = 1'b1;
        expq.delete();
        sent_model = 0;
        gap_cnt = 0;
        mon_en = 1'b1;
        repeat (20) begin
            @(negedge RX_CLK);
            check("post_reset_comma", 32'(KCHAR_TO_TX), 32'd3);
        end
        push(2, 0, 2, 1, 1'b1, acc);
        drain("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
